// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared sizing constants and types for the FIFO pointer/status
//            controller and its pointer sub-module.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Default pointer width; the FIFO holds 2**FIFO_ADDR_WIDTH words.
  localparam int FIFO_ADDR_WIDTH = 3;

  // Number of storage slots at the default pointer width.
  localparam int FIFO_DEPTH = 1 << FIFO_ADDR_WIDTH;

  // Pointer into the storage array at the default width.
  typedef logic [FIFO_ADDR_WIDTH-1:0] ptr_t;

  // Occupancy count at the default width; one extra bit so DEPTH is representable.
  typedef logic [FIFO_ADDR_WIDTH:0] cnt_t;

  // Level flags decoded purely from the registered occupancy count.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ptr
// Purpose  : Wrapping ADDR_WIDTH-bit pointer. Advances by one on each clock
//            with inc high, rolling from DEPTH-1 back to 0.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr
);

  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] ptr_d;
  logic [ADDR_WIDTH-1:0] ptr_q;

  // Next pointer: hold, or step forward with an explicit wrap at the last slot.
  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      if (ptr_q == PTR_LAST) begin
        ptr_d = PTR_ZERO;
      end else begin
        ptr_d = ptr_q + PTR_ONE;
      end
    end
  end

  // Pointer register with synchronous reset to slot 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= PTR_ZERO;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule : fifo_ptr
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl
// Purpose  : Pointer and status controller for a synchronous FWFT FIFO.
//            Drives the storage write strobe and write/read addresses, keeps
//            the occupancy count, and reports level flags plus one-cycle
//            overflow/underflow pulses.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Count-domain constants, sized to the count register.
  localparam logic [ADDR_WIDTH:0] CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_AF   = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] CNT_AE   = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [ADDR_WIDTH:0] cnt_d;
  logic [ADDR_WIDTH:0] cnt_q;
  logic                overflow_d;
  logic                overflow_q;
  logic                underflow_d;
  logic                underflow_q;
  logic                push_ok;
  logic                pop_ok;
  fifo_status_t        status;

  // Level flags come from the registered count only, never from wr/rd.
  always_comb begin
    status              = '0;
    status.full         = (cnt_q == CNT_FULL);
    status.empty        = (cnt_q == CNT_ZERO);
    status.almost_full  = (cnt_q >= CNT_AF);
    status.almost_empty = (cnt_q <= CNT_AE);
  end

  // Accept decisions. A push into a full FIFO is allowed when a pop frees the
  // head slot in the same cycle; reset suppresses both so nothing is written.
  always_comb begin
    push_ok = wr & (~status.full | rd) & ~reset;
    pop_ok  = rd & ~status.empty & ~reset;
  end

  // Occupancy and error-pulse next state.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    overflow_d  = wr & status.full & ~rd;
    underflow_d = rd & status.empty;
  end

  // Count and error-pulse registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= CNT_ZERO;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Write pointer: addresses the slot the next accepted push lands in.
  fifo_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_w_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push_ok),
    .ptr   (w_addr)
  );

  // Read pointer: always addresses the current head word.
  fifo_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_r_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop_ok),
    .ptr   (r_addr)
  );

  assign w_en         = push_ok;
  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign count        = cnt_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule : fifo_ctrl
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_ctrl
// Purpose  : Directed self-checking bench for fifo_ctrl at DEPTH = 8, with a
//            small behavioural storage array standing in for reg_file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

  logic       clk;
  logic       reset;
  logic       wr;
  logic       rd;
  logic       w_en;
  logic [2:0] w_addr;
  logic [2:0] r_addr;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  logic [7:0] din;
  logic [7:0] mem [0:7];
  logic [7:0] head;

  int tests;
  int fails;

  fifo_ctrl #(
    .ADDR_WIDTH (3),
    .AF_LEVEL   (6),
    .AE_LEVEL   (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .rd           (rd),
    .w_en         (w_en),
    .w_addr       (w_addr),
    .r_addr       (r_addr),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage array stand-in: synchronous write, asynchronous read of the head.
  always @(posedge clk) begin
    if (w_en) mem[w_addr] <= din;
  end
  assign head = mem[r_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of requests; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic w, input logic r, input logic [7:0] d);
    wr  = w;
    rd  = r;
    din = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_ae"}, 32'(almost_empty), 32'd1);
    chk({tag, "_af"}, 32'(almost_full), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_unf"}, 32'(underflow), 32'd0);
    chk({tag, "_waddr"}, 32'(w_addr), 32'd0);
    chk({tag, "_raddr"}, 32'(r_addr), 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    reset = 1'b1;
    wr    = 1'b0;
    rd    = 1'b0;
    din   = 8'h00;

    // Reset state, with a push request held during reset.
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 8'hEE);
    chk("rst_wen", 32'(w_en), 32'd0);
    tick();
    chk_reset_state("rst");
    reset = 1'b0;

    // Eight pushes 0x10..0x17.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 8'(8'h10 + i));
      chk("push_wen", 32'(w_en), 32'd1);
      chk("push_waddr", 32'(w_addr), 32'(i));
      tick();
      chk("push_count", 32'(count), 32'(i + 1));
      chk("push_af", 32'(almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
      chk("push_full", 32'(full), (i + 1 == 8) ? 32'd1 : 32'd0);
      chk("push_empty", 32'(empty), 32'd0);
    end
    chk("wrap_waddr", 32'(w_addr), 32'd0);

    // Push while full with no pop: dropped, overflow pulses once.
    drive(1'b1, 1'b0, 8'hAA);
    chk("ovf_wen", 32'(w_en), 32'd0);
    tick();
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_waddr", 32'(w_addr), 32'd0);
    drive(1'b0, 1'b0, 8'h00);
    tick();
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Eight pops; head word visible before each pop with no latency.
    for (int i = 0; i < 8; i++) begin
      chk("pop_head", 32'(head), 32'(8'h10 + i));
      chk("pop_raddr", 32'(r_addr), 32'(i));
      chk("pop_count", 32'(count), 32'(8 - i));
      chk("pop_ae", 32'(almost_empty), (8 - i <= 2) ? 32'd1 : 32'd0);
      drive(1'b0, 1'b1, 8'h00);
      tick();
    end
    chk("drained_empty", 32'(empty), 32'd1);
    chk("drained_count", 32'(count), 32'd0);
    chk("drained_ae", 32'(almost_empty), 32'd1);
    chk("drained_raddr", 32'(r_addr), 32'd0);
    chk("drained_full", 32'(full), 32'd0);

    // Pop while empty, no push.
    drive(1'b0, 1'b1, 8'h00);
    tick();
    chk("unf_pulse", 32'(underflow), 32'd1);
    chk("unf_count", 32'(count), 32'd0);
    chk("unf_raddr", 32'(r_addr), 32'd0);
    drive(1'b0, 1'b0, 8'h00);
    tick();
    chk("unf_clear", 32'(underflow), 32'd0);

    // Pop while empty with a push: only the push happens.
    drive(1'b1, 1'b1, 8'h20);
    chk("unfw_wen", 32'(w_en), 32'd1);
    tick();
    chk("unfw_pulse", 32'(underflow), 32'd1);
    chk("unfw_count", 32'(count), 32'd1);
    chk("unfw_empty", 32'(empty), 32'd0);
    chk("unfw_head", 32'(head), 32'h20);
    chk("unfw_raddr", 32'(r_addr), 32'd0);

    // Fill to count 4, then simultaneous push and pop.
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'(8'h20 + i));
      tick();
    end
    chk("mid_count", 32'(count), 32'd4);
    chk("mid_head", 32'(head), 32'h20);
    drive(1'b1, 1'b1, 8'h24);
    tick();
    chk("mid_rw_count", 32'(count), 32'd4);
    chk("mid_rw_raddr", 32'(r_addr), 32'd1);
    chk("mid_rw_waddr", 32'(w_addr), 32'd5);
    chk("mid_rw_head", 32'(head), 32'h21);

    // Fill to full (write pointer wraps), then simultaneous push and pop.
    for (int i = 5; i < 9; i++) begin
      drive(1'b1, 1'b0, 8'(8'h20 + i));
      tick();
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_waddr", 32'(w_addr), 32'd1);
    drive(1'b1, 1'b1, 8'h29);
    chk("full_rw_wen", 32'(w_en), 32'd1);
    tick();
    chk("full_rw_count", 32'(count), 32'd8);
    chk("full_rw_full", 32'(full), 32'd1);
    chk("full_rw_ovf", 32'(overflow), 32'd0);
    chk("full_rw_raddr", 32'(r_addr), 32'd2);
    chk("full_rw_waddr", 32'(w_addr), 32'd2);

    // Order check after the wrap: 0x22, 0x23, 0x24 come out next.
    for (int i = 2; i < 5; i++) begin
      chk("order_head", 32'(head), 32'(8'h20 + i));
      drive(1'b0, 1'b1, 8'h00);
      tick();
    end
    chk("order_count", 32'(count), 32'd5);
    chk("order_tail", 32'(mem[1]), 32'h29);

    // Reset at count 5 with a push request: push dropped, reset values shown.
    reset = 1'b1;
    drive(1'b1, 1'b0, 8'h55);
    chk("midrst_wen", 32'(w_en), 32'd0);
    tick();
    reset = 1'b0;
    chk_reset_state("midrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_fifo_ctrl
`default_nettype wire

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and status controller for the synchronous FIFO; sits directly upstream of the `reg_file` storage array and drives its `w_en`, `w_addr` and `r_addr`. The controller accepts push/pop requests, maintains wrap-around read/write pointers and an occupancy count, and produces full/empty, almost-full/almost-empty and overflow/underflow status. Reads are first-word-fall-through: while `empty` is low, the `reg_file` asynchronous read at `r_addr` already presents the head word.

## Interface
- `ADDR_WIDTH`, default 3: pointer width; DEPTH = 2**ADDR_WIDTH.
- `AF_LEVEL`, default 6: `almost_full` threshold; legal range 1..DEPTH.
- `AE_LEVEL`, default 2: `almost_empty` threshold; legal range 0..DEPTH-1.
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `wr`, input, 1: push request.
- `rd`, input, 1: pop request; consumes the head word.
- `w_en`, output, 1: write strobe to `reg_file`.
- `w_addr`, output, ADDR_WIDTH: write pointer.
- `r_addr`, output, ADDR_WIDTH: read pointer, which is the head of the FIFO.
- `full`, output, 1: count == DEPTH.
- `empty`, output, 1: count == 0.
- `almost_full`, output, 1: count >= AF_LEVEL.
- `almost_empty`, output, 1: count <= AE_LEVEL.
- `count`, output, ADDR_WIDTH+1: current occupancy, 0..DEPTH.
- `overflow`, output, 1: one-cycle pulse when a push is dropped.
- `underflow`, output, 1: one-cycle pulse when a pop is dropped.

## Operation
- State is held in three registers: `w_ptr`, `r_ptr` and `cnt`.
- `full`, `empty`, `almost_full` and `almost_empty` are decoded from `cnt` only. There is no combinational path from `wr`/`rd` to these flags.
- Accepted operations:
  - push_ok = wr & (~full | rd).
  - pop_ok = rd & ~empty.
- `w_en` = push_ok. This is combinational and is the only wr/rd-to-output path.
- Updates on each clock edge:
  - On push_ok: `w_ptr` increments, wrapping DEPTH-1 → 0.
  - On pop_ok: `r_ptr` increments, wrapping the same way.
  - `cnt`: +1 if push_ok & ~pop_ok; −1 if pop_ok & ~push_ok; otherwise held.
- Simultaneous events:
  - Empty with wr & rd: only the push occurs (count 0→1); `underflow` pulses.
  - Full with wr & rd: both occur and count stays DEPTH. The pop sees the old head this cycle; the write lands in the freed slot at the edge.
  - Neither full nor empty, wr & rd: both occur; count unchanged.
- Error pulses (registered, high for exactly the cycle after the offending request):
  - `overflow`: wr & full & ~rd.
  - `underflow`: rd & empty.
- Dropped requests change no state.

## Timing
- Reset values: `w_ptr` = 0, `r_ptr` = 0, `cnt` = 0, `empty` = 1, `full` = 0, `almost_empty` = 1, `almost_full` = 0, `overflow` = 0, `underflow` = 0, `w_en` = 0 while `reset` is high.
- Reset has priority over wr/rd in the same cycle. Reset mid-operation discards all contents; storage is not cleared.
- Flag latency is one cycle. A push at edge N makes `empty` fall after edge N, so the head is readable in cycle N+1. A pop at edge N updates `full` and `count` after edge N.
- Read data latency is zero: `r_addr` changes with `r_ptr`, and the head word appears combinationally through `reg_file`.
- Sustained throughput is one push and one pop per cycle.

## Structure
- Package `fifo_pkg` holds:
  - default `ADDR_WIDTH`;
  - `ptr_t` (logic [ADDR_WIDTH-1:0]);
  - `cnt_t` (logic [ADDR_WIDTH:0]);
  - the DEPTH constant.
- Sub-module `fifo_ptr`: a wrapping ADDR_WIDTH-bit counter with `clk`, `reset` and `inc` inputs. It is instantiated twice, for the write and read pointers.
- The FIFO top instantiates `fifo_ctrl` and `reg_file` side by side, sharing ADDR_WIDTH.

## Test plan
All scenarios use DEPTH = 8.
- Reset, then 8 pushes of 0x10..0x17 → `count` steps 1..8; `almost_full` rises at count 6; `full` rises after the 8th edge; `w_addr` wraps to 0.
- From full, a push with rd = 0 → no pointer change; `overflow` high for one cycle; `count` stays 8.
- 8 pops → head data reads 0x10..0x17 in order with no latency; `empty` = 1; `almost_empty` rises at count 2.
- Pop while empty, with and without wr → `underflow` pulses. With wr = 1, `count` goes 0→1 and the new word is visible next cycle.
- Simultaneous wr & rd at count 8 and at count 4 → `count` unchanged, both pointers advance, FIFO order preserved.
- Assert `reset` at count 5 with wr = 1 → the next cycle shows all reset values and the push is dropped.
